vector_packer: RTL and testbench

//   Packs variable-length input vectors (1..N valid lanes, length chosen per chain by firmware) into full N-lane

---
 rtl/vector_packer_pkg.sv | 40 ++++
 rtl/vector_packer_cfg.sv | 47 ++++
 rtl/vector_packer.sv | 162 ++++++++++++++++
 tb/tb_vector_packer.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vector_packer_pkg.sv
// Shared types and helpers for the vector packer: firmware condition codes and
// the per-vector condition evaluator.
package vector_packer_pkg;

    typedef enum logic [7:0] {
        COND_NONE           = 8'd0,
        COND_LAST_INNER     = 8'd1,
        COND_NOTLAST_INNER  = 8'd2,
        COND_FIRST_INNER    = 8'd3,
        COND_NOTFIRST_INNER = 8'd4,
        COND_LAST_OUTER     = 8'd5,
        COND_NOTLAST_OUTER  = 8'd6,
        COND_FIRST_OUTER    = 8'd7,
        COND_NOTFIRST_OUTER = 8'd8
    } cond_e;

    localparam logic [7:0] LEN_DROP = 8'd0;

    // Codes above COND_NOTFIRST_OUTER never match, so such a chain drops everything.
    function automatic logic cond_match(input logic [7:0] cond,
                                        input logic [1:0] eof,
                                        input logic [1:0] bof);
        logic m;
        m = 1'b0;
        case (cond)
            COND_NONE:           m = 1'b1;
            COND_LAST_INNER:     m = eof[0];
            COND_NOTLAST_INNER:  m = !eof[0];
            COND_FIRST_INNER:    m = bof[0];
            COND_NOTFIRST_INNER: m = !bof[0];
            COND_LAST_OUTER:     m = eof[1];
            COND_NOTLAST_OUTER:  m = !eof[1];
            COND_FIRST_OUTER:    m = bof[1];
            COND_NOTFIRST_OUTER: m = !bof[1];
            default:             m = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/vector_packer_cfg.sv
// Byte-serial firmware table for the vector packer: condition bytes for every
// chain first, then length bytes for every chain.
module vector_packer_cfg
    import vector_packer_pkg::*;
#(
    parameter int                       MAX_CHAINS            = 4,
    parameter logic [7:0]               PERSONAL_CONFIG_ID    = 8'd0,
    parameter logic [8*MAX_CHAINS-1:0]  INITIAL_FIRMWARE_LEN  = '0,
    parameter logic [8*MAX_CHAINS-1:0]  INITIAL_FIRMWARE_COND = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       tracing,
    input  logic [7:0]                 configId,
    input  logic [7:0]                 configData,
    output logic [8*MAX_CHAINS-1:0]    firmware_len,
    output logic [8*MAX_CHAINS-1:0]    firmware_cond
);

    localparam int              BC_W   = $clog2(2*MAX_CHAINS+1);
    localparam logic [BC_W-1:0] BC_MAX = BC_W'(2*MAX_CHAINS);

    logic [BC_W-1:0] byte_counter;

    // Saturating counter means bytes past the table end are silently ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_counter  <= '0;
            firmware_len  <= INITIAL_FIRMWARE_LEN;
            firmware_cond <= INITIAL_FIRMWARE_COND;
        end else if (!tracing) begin
            if (configId == PERSONAL_CONFIG_ID) begin
                if (byte_counter != BC_MAX)
                    byte_counter <= byte_counter + 1'b1;
                for (int c = 0; c < MAX_CHAINS; c++) begin
                    if (byte_counter == BC_W'(c))
                        firmware_cond[c*8 +: 8] <= configData;
                    if (byte_counter == BC_W'(c + MAX_CHAINS))
                        firmware_len[c*8 +: 8] <= configData;
                end
            end else begin
                byte_counter <= '0;
            end
        end
    end

endmodule

// File: rtl/vector_packer.sv
// Packs 1..N-lane input vectors into gapless N-lane output vectors with a 2N-lane
// residual buffer, ready/valid output and flush. DATA_PACKER_TIMEOUT_EN adds an idle auto-flush.
module vector_packer
    import vector_packer_pkg::*;
#(
    parameter int                       N                     = 8,
    parameter int                       DATA_WIDTH            = 32,
    parameter int                       MAX_CHAINS            = 4,
    parameter logic [7:0]               PERSONAL_CONFIG_ID    = 8'd0,
    parameter logic [8*MAX_CHAINS-1:0]  INITIAL_FIRMWARE_LEN  = '0,
    parameter logic [8*MAX_CHAINS-1:0]  INITIAL_FIRMWARE_COND = '0,
    parameter int                       TIMEOUT_CYCLES        = 64
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  tracing,
    input  logic                                  valid_in,
    output logic                                  ready_in,
    input  logic [1:0]                            eof_in,
    input  logic [1:0]                            bof_in,
    input  logic [$clog2(MAX_CHAINS)-1:0]         chainId_in,
    input  logic [DATA_WIDTH*N-1:0]               vector_in,
    input  logic                                  flush_in,
    input  logic [7:0]                            configId,
    input  logic [7:0]                            configData,
    output logic [DATA_WIDTH*N-1:0]               vector_out,
    output logic [$clog2(N+1)-1:0]                out_count,
    output logic                                  valid_out,
    input  logic                                  ready_out
);

    localparam int               CNT_W = $clog2(2*N);
    localparam int               OC_W  = $clog2(N+1);
    localparam int               LI_W  = $clog2(N);
    localparam logic [CNT_W:0]   N_T   = (CNT_W+1)'(N);

    logic [8*MAX_CHAINS-1:0] firmware_len;
    logic [8*MAX_CHAINS-1:0] firmware_cond;

    vector_packer_cfg #(
        .MAX_CHAINS            (MAX_CHAINS),
        .PERSONAL_CONFIG_ID    (PERSONAL_CONFIG_ID),
        .INITIAL_FIRMWARE_LEN  (INITIAL_FIRMWARE_LEN),
        .INITIAL_FIRMWARE_COND (INITIAL_FIRMWARE_COND)
    ) u_cfg (
        .clk           (clk),
        .rst_n         (rst_n),
        .tracing       (tracing),
        .configId      (configId),
        .configData    (configData),
        .firmware_len  (firmware_len),
        .firmware_cond (firmware_cond)
    );

    logic [DATA_WIDTH-1:0] buffer  [2*N];
    logic [DATA_WIDTH-1:0] merged  [2*N];
    logic [DATA_WIDTH-1:0] in_lane [N];
    logic [CNT_W-1:0]      cnt, cnt_n;
    logic [CNT_W:0]        total, len_add, emit_cnt;
    logic                  flush_pending, flush_pending_n;
    logic [7:0]            fw_len, fw_cond;
    logic                  len_ok, accept, out_free, flush_req, do_flush, timeout_hit;

    assign fw_len  = firmware_len [{chainId_in, 3'b000} +: 8];
    assign fw_cond = firmware_cond[{chainId_in, 3'b000} +: 8];
    assign len_ok  = (fw_len != LEN_DROP) && (fw_len <= 8'(N));

    // Output slot can take a new word this cycle; doubles as the input-side ready.
    assign out_free = !valid_out || ready_out;
    assign ready_in = out_free;
    assign accept   = valid_in && ready_in && tracing && len_ok
                      && cond_match(fw_cond, eof_in, bof_in);

    assign flush_req = tracing && (flush_in || timeout_hit);
    assign do_flush  = flush_req || flush_pending;

`ifdef DATA_PACKER_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES+1);
    logic [TMR_W-1:0] idle_tmr;

    // Reloaded while empty or on accept; reaching zero with data held means idle timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            idle_tmr <= TMR_W'(TIMEOUT_CYCLES - 1);
        else if (accept || cnt == '0)
            idle_tmr <= TMR_W'(TIMEOUT_CYCLES - 1);
        else if (idle_tmr != '0)
            idle_tmr <= idle_tmr - 1'b1;
    end

    assign timeout_hit = (idle_tmr == '0) && (cnt != '0) && tracing;
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        for (int i = 0; i < N; i++)
            in_lane[i] = vector_in[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // Residual followed by the accepted lanes; everything past total reads as zero,
    // which gives the zero padding of partial flushes for free.
    always_comb begin
        for (int i = 0; i < 2*N; i++) begin
            merged[i] = '0;
            if (i < int'(cnt))
                merged[i] = buffer[i];
            else if (accept && (i - int'(cnt)) < int'(fw_len))
                merged[i] = in_lane[LI_W'(i - int'(cnt))];
        end
    end

    assign len_add = accept ? fw_len[CNT_W:0] : '0;

    always_comb begin
        total           = {1'b0, cnt} + len_add;
        emit_cnt        = '0;
        flush_pending_n = flush_pending;
        if (out_free) begin
            if (do_flush && total != '0) begin
                emit_cnt        = (total > N_T) ? N_T : total;
                flush_pending_n = (total > N_T);
            end else begin
                if (total >= N_T)
                    emit_cnt = N_T;
                if (do_flush)
                    flush_pending_n = 1'b0;
            end
        end else if (flush_req && cnt != '0) begin
            flush_pending_n = 1'b1;
        end
        cnt_n = CNT_W'(total - emit_cnt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt           <= '0;
            flush_pending <= 1'b0;
            valid_out     <= 1'b0;
            vector_out    <= '0;
            out_count     <= '0;
            for (int i = 0; i < 2*N; i++)
                buffer[i] <= '0;
        end else begin
            cnt           <= cnt_n;
            flush_pending <= flush_pending_n;
            for (int i = 0; i < N; i++)
                buffer[i] <= (emit_cnt != '0) ? merged[i+N] : merged[i];
            for (int i = N; i < 2*N; i++)
                buffer[i] <= (emit_cnt != '0) ? '0 : merged[i];
            if (out_free) begin
                valid_out <= (emit_cnt != '0);
                if (emit_cnt != '0) begin
                    out_count <= OC_W'(emit_cnt);
                    for (int i = 0; i < N; i++)
                        vector_out[i*DATA_WIDTH +: DATA_WIDTH] <= merged[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_vector_packer.sv
// Directed self-checking bench for vector_packer (N=8, 32-bit lanes, 4 chains).
module tb_vector_packer;

    localparam int N  = 8;
    localparam int DW = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             tracing;
    logic             valid_in;
    logic             ready_in;
    logic [1:0]       eof_in, bof_in;
    logic [1:0]       chainId_in;
    logic [DW*N-1:0]  vector_in;
    logic             flush_in;
    logic [7:0]       configId, configData;
    logic [DW*N-1:0]  vector_out;
    logic [3:0]       out_count;
    logic             valid_out;
    logic             ready_out;

    int vec_cnt = 0;
    int err_cnt = 0;

    vector_packer #(.TIMEOUT_CYCLES(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tracing    (tracing),
        .valid_in   (valid_in),
        .ready_in   (ready_in),
        .eof_in     (eof_in),
        .bof_in     (bof_in),
        .chainId_in (chainId_in),
        .vector_in  (vector_in),
        .flush_in   (flush_in),
        .configId   (configId),
        .configData (configData),
        .vector_out (vector_out),
        .out_count  (out_count),
        .valid_out  (valid_out),
        .ready_out  (ready_out)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Lanes beyond len carry junk so that a packer reading them is caught.
    task automatic set_vec(input int base, input int len);
        for (int i = 0; i < N; i++)
            vector_in[i*DW +: DW] = (i < len) ? 32'(base + i) : (32'hDEAD_0000 | 32'(i));
    endtask

    function automatic logic [DW*N-1:0] exp_vec(input int base, input int n);
        logic [DW*N-1:0] v;
        v = '0;
        for (int i = 0; i < n; i++)
            v[i*DW +: DW] = 32'(base + i);
        return v;
    endfunction

    // Byte k of the table sits in bytes[k*8 +: 8].
    task automatic cfg_write(input logic [63:0] bytes);
        tracing  = 1'b0;
        configId = 8'h55;
        tick();
        configId = 8'h00;
        for (int k = 0; k < 8; k++) begin
            configData = bytes[k*8 +: 8];
            tick();
        end
        configId = 8'h55;
        tracing  = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        vec_cnt++; if (valid_out !== 1'b0) begin err_cnt++; $display("FAIL reset_valid: got %b want 0", valid_out); end
        vec_cnt++; if (vector_out !== '0) begin err_cnt++; $display("FAIL reset_vector: got %h want 0", vector_out); end
        vec_cnt++; if (out_count !== 4'd0) begin err_cnt++; $display("FAIL reset_count: got %0d want 0", out_count); end
        vec_cnt++; if (ready_in !== 1'b1) begin err_cnt++; $display("FAIL reset_ready_in: got %b want 1", ready_in); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_full_lane();
        chainId_in = 2'd0; ready_out = 1'b1; valid_in = 1'b1;
        set_vec(0, 8);
        tick();
        vec_cnt++; if (valid_out !== 1'b1) begin err_cnt++; $display("FAIL full_valid0: got %b want 1", valid_out); end
        vec_cnt++; if (vector_out !== exp_vec(0, 8)) begin err_cnt++; $display("FAIL full_vec0: got %h want %h", vector_out, exp_vec(0, 8)); end
        vec_cnt++; if (out_count !== 4'd8) begin err_cnt++; $display("FAIL full_count0: got %0d want 8", out_count); end
        set_vec(8, 8);
        tick();
        vec_cnt++; if (valid_out !== 1'b1) begin err_cnt++; $display("FAIL full_valid1: got %b want 1", valid_out); end
        vec_cnt++; if (vector_out !== exp_vec(8, 8)) begin err_cnt++; $display("FAIL full_vec1: got %h want %h", vector_out, exp_vec(8, 8)); end
        valid_in = 1'b0;
        tick();
        vec_cnt++; if (valid_out !== 1'b0) begin err_cnt++; $display("FAIL full_idle: got %b want 0", valid_out); end
    endtask

    task automatic test_pack_l3();
        chainId_in = 2'd1; valid_in = 1'b1;
        set_vec(1, 3);
        tick();
        vec_cnt++; if (valid_out !== 1'b0) begin err_cnt++; $display("FAIL l3_valid_a: got %b want 0", valid_out); end
        set_vec(4, 3);
        tick();
        vec_cnt++; if (valid_out !== 1'b0) begin err_cnt++; $display("FAIL l3_valid_b: got %b want 0", valid_out); end
        set_vec(7, 3);
        tick();
        vec_cnt++; if (valid_out !== 1'b1) begin err_cnt++; $display("FAIL l3_valid_c: got %b want 1", valid_out); end
        vec_cnt++; if (vector_out !== exp_vec(1, 8)) begin err_cnt++; $display("FAIL l3_vec: got %h want %h", vector_out, exp_vec(1, 8)); end
        vec_cnt++; if (out_count !== 4'd8) begin err_cnt++; $display("FAIL l3_count: got %0d want 8", out_count); end
        valid_in = 1'b0; flush_in = 1'b1;
        tick();
        flush_in = 1'b0;
        vec_cnt++; if (valid_out !== 1'b1) begin err_cnt++; $display("FAIL l3_flush_valid: got %b want 1", valid_out); end
        vec_cnt++; if (vector_out !== exp_vec(9, 1)) begin err_cnt++; $display("FAIL l3_flush_vec: got %h want %h", vector_out, exp_vec(9, 1)); end
        vec_cnt++; if (out_count !== 4'd1) begin err_cnt++; $display("FAIL l3_flush_count: got %0d want 1", out_count); end
        tick();
        vec_cnt++; if (valid_out !== 1'b0) begin err_cnt++; $display("FAIL l3_after_flush: got %b want 0", valid_out); end
    endtask

    task automatic test_backpressure();
        chainId_in = 2'd0; ready_out = 1'b0; valid_in = 1'b1;
        set_vec(100, 8);
        tick();
        vec_cnt++; if (vector_out !== exp_vec(100, 8)) begin err_cnt++; $display("FAIL bp_first: got %h want %h", vector_out, exp_vec(100, 8)); end
        set_vec(108, 8);
        #1;
        vec_cnt++; if (ready_in !== 1'b0) begin err_cnt++; $display("FAIL bp_ready_low: got %b want 0", ready_in); end
        for (int c = 0; c < 4; c++) begin
            tick();
            vec_cnt++; if (ready_in !== 1'b0) begin err_cnt++; $display("FAIL bp_ready_hold%0d: got %b want 0", c, ready_in); end
            vec_cnt++; if (valid_out !== 1'b1 || vector_out !== exp_vec(100, 8)) begin err_cnt++; $display("FAIL bp_stable%0d: got %b/%h want 1/%h", c, valid_out, vector_out, exp_vec(100, 8)); end
        end
        ready_out = 1'b1;
        #1;
        vec_cnt++; if (ready_in !== 1'b1) begin err_cnt++; $display("FAIL bp_ready_release: got %b want 1", ready_in); end
        tick();
        vec_cnt++; if (valid_out !== 1'b1 || vector_out !== exp_vec(108, 8)) begin err_cnt++; $display("FAIL bp_no_loss: got %b/%h want 1/%h", valid_out, vector_out, exp_vec(108, 8)); end
        valid_in = 1'b0;
        tick();
        vec_cnt++; if (valid_out !== 1'b0) begin err_cnt++; $display("FAIL bp_drain: got %b want 0", valid_out); end
    endtask

    task automatic test_flush_same_cycle();
        chainId_in = 2'd2; valid_in = 1'b1;
        set_vec('h200, 5);
        tick();
        vec_cnt++; if (valid_out !== 1'b0) begin err_cnt++; $display("FAIL fsc_hold: got %b want 0", valid_out); end
        set_vec('h205, 5); flush_in = 1'b1;
        tick();
        valid_in = 1'b0; flush_in = 1'b0;
        vec_cnt++; if (valid_out !== 1'b1 || out_count !== 4'd8) begin err_cnt++; $display("FAIL fsc_first: got %b/%0d want 1/8", valid_out, out_count); end
        vec_cnt++; if (vector_out !== exp_vec('h200, 8)) begin err_cnt++; $display("FAIL fsc_first_vec: got %h want %h", vector_out, exp_vec('h200, 8)); end
        tick();
        vec_cnt++; if (valid_out !== 1'b1 || out_count !== 4'd2) begin err_cnt++; $display("FAIL fsc_second: got %b/%0d want 1/2", valid_out, out_count); end
        vec_cnt++; if (vector_out !== exp_vec('h208, 2)) begin err_cnt++; $display("FAIL fsc_second_vec: got %h want %h", vector_out, exp_vec('h208, 2)); end
        tick();
        vec_cnt++; if (valid_out !== 1'b0) begin err_cnt++; $display("FAIL fsc_pending_clear: got %b want 0", valid_out); end
    endtask

    task automatic test_flush_stalled();
        chainId_in = 2'd2; valid_in = 1'b1; ready_out = 1'b1;
        set_vec('h400, 5);
        tick();
        set_vec('h405, 5);
        tick();
        valid_in = 1'b0; ready_out = 1'b0; flush_in = 1'b1;
        tick();
        flush_in = 1'b0;
        vec_cnt++; if (valid_out !== 1'b1 || vector_out !== exp_vec('h400, 8)) begin err_cnt++; $display("FAIL fst_stall_a: got %b/%h want 1/%h", valid_out, vector_out, exp_vec('h400, 8)); end
        tick();
        vec_cnt++; if (out_count !== 4'd8 || vector_out !== exp_vec('h400, 8)) begin err_cnt++; $display("FAIL fst_stall_b: got %0d/%h want 8/%h", out_count, vector_out, exp_vec('h400, 8)); end
        ready_out = 1'b1;
        tick();
        vec_cnt++; if (valid_out !== 1'b1 || out_count !== 4'd2) begin err_cnt++; $display("FAIL fst_served: got %b/%0d want 1/2", valid_out, out_count); end
        vec_cnt++; if (vector_out !== exp_vec('h408, 2)) begin err_cnt++; $display("FAIL fst_served_vec: got %h want %h", vector_out, exp_vec('h408, 2)); end
        tick();
        vec_cnt++; if (valid_out !== 1'b0) begin err_cnt++; $display("FAIL fst_done: got %b want 0", valid_out); end
    endtask

    // chain0: cond eof[0] set, len 2; chain1: cond 9 (never); chain2: len 0; chain3: len 8.
    task automatic test_config_drop();
        logic [DW*N-1:0] want;
        valid_in = 1'b1; chainId_in = 2'd3; set_vec('h666, 8);
        cfg_write(64'h08_00_08_02_00_00_09_01);
        valid_in = 1'b0;
        vec_cnt++; if (valid_out !== 1'b0) begin err_cnt++; $display("FAIL cfg_ignored_in_config: got %b want 0", valid_out); end
        valid_in = 1'b1;
        chainId_in = 2'd0; eof_in = 2'b00; set_vec('h500, 2); tick();
        chainId_in = 2'd0; eof_in = 2'b01; set_vec('h510, 2); tick();
        chainId_in = 2'd1; eof_in = 2'b01; set_vec('h580, 8); tick();
        chainId_in = 2'd0; eof_in = 2'b01; set_vec('h520, 2); tick();
        chainId_in = 2'd2; eof_in = 2'b01; set_vec('h590, 8); tick();
        chainId_in = 2'd0; eof_in = 2'b11; set_vec('h530, 2); tick();
        vec_cnt++; if (valid_out !== 1'b0) begin err_cnt++; $display("FAIL cfg_partial: got %b want 0", valid_out); end
        chainId_in = 2'd0; eof_in = 2'b01; set_vec('h540, 2); tick();
        want = '0;
        for (int k = 0; k < 4; k++)
            for (int j = 0; j < 2; j++)
                want[(2*k+j)*DW +: DW] = 32'('h510 + 16*k + j);
        vec_cnt++; if (valid_out !== 1'b1 || vector_out !== want) begin err_cnt++; $display("FAIL cfg_packed: got %b/%h want 1/%h", valid_out, vector_out, want); end
        valid_in = 1'b0; eof_in = 2'b00;
        tick();
        vec_cnt++; if (valid_out !== 1'b0) begin err_cnt++; $display("FAIL cfg_idle: got %b want 0", valid_out); end
    endtask

    task automatic test_reset_mid();
        valid_in = 1'b1; eof_in = 2'b01;
        chainId_in = 2'd0; set_vec('h600, 2); tick();
        chainId_in = 2'd0; set_vec('h602, 2); tick();
        chainId_in = 2'd3; set_vec('h604, 8); tick();
        valid_in = 1'b0; eof_in = 2'b00;
        vec_cnt++; if (valid_out !== 1'b1 || vector_out !== exp_vec('h600, 8)) begin err_cnt++; $display("FAIL rst_mid_pre: got %b/%h want 1/%h", valid_out, vector_out, exp_vec('h600, 8)); end
        #2;
        rst_n = 1'b0;
        #1;
        vec_cnt++; if (valid_out !== 1'b0 || out_count !== 4'd0) begin err_cnt++; $display("FAIL rst_mid_ctrl: got %b/%0d want 0/0", valid_out, out_count); end
        vec_cnt++; if (vector_out !== '0) begin err_cnt++; $display("FAIL rst_mid_vec: got %h want 0", vector_out); end
        tick();
        rst_n = 1'b1;
        valid_in = 1'b1; chainId_in = 2'd3; set_vec('h680, 8);
        tick();
        valid_in = 1'b0;
        tick();
        vec_cnt++; if (valid_out !== 1'b0) begin err_cnt++; $display("FAIL rst_mid_fw_revert: got %b want 0", valid_out); end
        flush_in = 1'b1;
        tick();
        flush_in = 1'b0;
        vec_cnt++; if (valid_out !== 1'b0) begin err_cnt++; $display("FAIL rst_mid_cnt_clear: got %b want 0", valid_out); end
    endtask

    task automatic test_timeout();
        cfg_write(64'h02_02_02_02_00_00_00_00);
        chainId_in = 2'd0; valid_in = 1'b1; set_vec('h700, 2);
        tick();
        valid_in = 1'b0;
        vec_cnt++; if (valid_out !== 1'b0) begin err_cnt++; $display("FAIL to_hold: got %b want 0", valid_out); end
`ifdef DATA_PACKER_TIMEOUT_EN
        for (int c = 0; c < 3; c++) begin
            tick();
            vec_cnt++; if (valid_out !== 1'b0) begin err_cnt++; $display("FAIL to_early%0d: got %b want 0", c, valid_out); end
        end
        tick();
`else
        repeat (10) tick();
        vec_cnt++; if (valid_out !== 1'b0) begin err_cnt++; $display("FAIL to_no_autoflush: got %b want 0", valid_out); end
        flush_in = 1'b1;
        tick();
        flush_in = 1'b0;
`endif
        vec_cnt++; if (valid_out !== 1'b1 || out_count !== 4'd2) begin err_cnt++; $display("FAIL to_partial: got %b/%0d want 1/2", valid_out, out_count); end
        vec_cnt++; if (vector_out !== exp_vec('h700, 2)) begin err_cnt++; $display("FAIL to_partial_vec: got %h want %h", vector_out, exp_vec('h700, 2)); end
        tick();
        vec_cnt++; if (valid_out !== 1'b0) begin err_cnt++; $display("FAIL to_after: got %b want 0", valid_out); end
    endtask

    initial begin
        rst_n = 1'b0; tracing = 1'b0; valid_in = 1'b0; eof_in = 2'b00; bof_in = 2'b00;
        chainId_in = 2'd0; vector_in = '0; flush_in = 1'b0; configId = 8'h55;
        configData = 8'h00; ready_out = 1'b1;
        test_reset();
        // lens {8,3,5,2}, all conds "always"
        cfg_write(64'h02_05_03_08_00_00_00_00);
        test_full_lane();
        test_pack_l3();
        test_backpressure();
        test_flush_same_cycle();
        test_flush_stalled();
        test_config_drop();
        test_reset_mid();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
